seg_display_scanner: RTL and testbench

Downstream consumer of the 4-bit to 7-segment decoder stage. It takes four 7-bit segment codes, one decoder output per digit, and time-multiplexes them onto a shared common-anode 4-digit display. It provides a per-digit refresh slot and a blanking interval at the start of each slot to suppress ghosting. New codes are double-buffered and applied only at frame boundaries, so the display never shows a torn frame.

---
 rtl/seg_display_scanner.sv | 93 +++++++++
 tb/tb_seg_display_scanner.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_scanner
// Purpose  : Time-multiplexes four 7-segment codes onto a common-anode display
//            with per-slot blanking and frame-synchronous double buffering.
// Revision : 1.0
// ============================================================================
module seg_display_scanner #(
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [27:0] seg_in,
    input  logic [3:0]  digit_en,
    output logic [3:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        frame_tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0][6:0] shadow_code_q, shadow_code_d;
    logic [3:0]      shadow_en_q, shadow_en_d;
    logic [3:0][6:0] active_code_q, active_code_d;
    logic [3:0]      active_en_q, active_en_d;
    logic [3:0]      an_n_q, an_n_d;
    logic [6:0]      seg_n_q, seg_n_d;
    logic            tick_q, tick_d;

    logic            slot_last;
    logic            frame_end;
    logic            blank;

    always_comb begin
        slot_last = (cnt_q == CW'(PRESCALE - 1));
        frame_end = slot_last && (idx_q == 2'd3);

        cnt_d = slot_last ? '0 : cnt_q + 1'b1;
        idx_d = slot_last ? idx_q + 2'd1 : idx_q;

        shadow_code_d = load ? seg_in   : shadow_code_q;
        shadow_en_d   = load ? digit_en : shadow_en_q;

        // Active set samples the registered shadow, so a load landing on the
        // boundary edge is deferred to the following frame.
        active_code_d = frame_end ? shadow_code_q : active_code_q;
        active_en_d   = frame_end ? shadow_en_q   : active_en_q;
        tick_d        = frame_end;

        blank = (int'(cnt_q) < BLANK) || !active_en_q[idx_q];
        if (blank) begin
            an_n_d  = 4'b1111;
            seg_n_d = 7'h7F;
        end else begin
            an_n_d  = ~(4'b0001 << idx_q);
            seg_n_d = ~active_code_q[idx_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            idx_q         <= 2'd0;
            shadow_code_q <= '0;
            shadow_en_q   <= 4'b0000;
            active_code_q <= '0;
            active_en_q   <= 4'b0000;
            an_n_q        <= 4'b1111;
            seg_n_q       <= 7'h7F;
            tick_q        <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shadow_code_q <= shadow_code_d;
            shadow_en_q   <= shadow_en_d;
            active_code_q <= active_code_d;
            active_en_q   <= active_en_d;
            an_n_q        <= an_n_d;
            seg_n_q       <= seg_n_d;
            tick_q        <= tick_d;
        end
    end

    assign an_n       = an_n_q;
    assign seg_n      = seg_n_q;
    assign frame_tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_display_scanner
// Purpose  : Directed, table-driven bench for seg_display_scanner (PRESCALE=8,
//            BLANK=2, 32-cycle frame).
// Revision : 1.0
// ============================================================================
module tb_seg_display_scanner;

    localparam int          PRESCALE = 8;
    localparam int          BLANK    = 2;
    localparam logic [27:0] PAT_3210 = {7'h4F, 7'h5B, 7'h06, 7'h3F};
    localparam logic [27:0] PAT_ALL  = 28'hFFFFFFF;
    localparam logic [27:0] PAT_B    = {7'h01, 7'h02, 7'h04, 7'h08};
    localparam logic [27:0] PAT_C    = {7'h10, 7'h20, 7'h40, 7'h00};

    logic        clk;
    logic        rst;
    logic        load;
    logic [27:0] seg_in;
    logic [3:0]  digit_en;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic        frame_tick;

    int checks;
    int errors;

    typedef struct {
        logic [27:0] seg;
        logic [3:0]  en;
        int          phase;
        logic [3:0]  an;
        logic [6:0]  sg;
    } vec_t;

    vec_t vecs [15];

    seg_display_scanner #(
        .PRESCALE (PRESCALE),
        .BLANK    (BLANK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .seg_in     (seg_in),
        .digit_en   (digit_en),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .frame_tick (frame_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_inv();
        chk("inv_onehot", 32'($countones(~an_n) <= 1), 32'd1);
        chk("inv_dark", 32'((an_n != 4'hF) || (seg_n == 7'h7F)), 32'd1);
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        check_inv();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Returns on the sample where frame_tick is high (state is frame phase 0).
    task automatic wait_tick();
        int budget;
        budget = 40;
        tick();
        while (frame_tick !== 1'b1 && budget > 0) begin
            tick();
            budget--;
        end
        chk("wait_frame_tick", 32'(frame_tick), 32'd1);
    endtask

    task automatic do_load(input logic [27:0] s, input logic [3:0] e);
        load     = 1'b1;
        seg_in   = s;
        digit_en = e;
        tick();
        load     = 1'b0;
        seg_in   = '0;
        digit_en = 4'h0;
    endtask

    initial begin
        logic [6:0] exp_seg [4];
        logic [3:0] onehot;
        int         lo_cnt  [4];
        int         dark_cnt;

        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        load     = 1'b0;
        seg_in   = '0;
        digit_en = 4'h0;

        vecs[0]  = '{PAT_3210, 4'hF, 0,  4'hF, 7'h7F};
        vecs[1]  = '{PAT_3210, 4'hF, 1,  4'hF, 7'h7F};
        vecs[2]  = '{PAT_3210, 4'hF, 2,  4'hE, 7'h40};
        vecs[3]  = '{PAT_3210, 4'hF, 7,  4'hE, 7'h40};
        vecs[4]  = '{PAT_3210, 4'hF, 8,  4'hF, 7'h7F};
        vecs[5]  = '{PAT_3210, 4'hF, 10, 4'hD, 7'h79};
        vecs[6]  = '{PAT_3210, 4'hF, 18, 4'hB, 7'h24};
        vecs[7]  = '{PAT_3210, 4'hF, 31, 4'h7, 7'h30};
        vecs[8]  = '{PAT_3210, 4'h5, 3,  4'hE, 7'h40};
        vecs[9]  = '{PAT_3210, 4'h5, 12, 4'hF, 7'h7F};
        vecs[10] = '{PAT_3210, 4'h5, 20, 4'hB, 7'h24};
        vecs[11] = '{PAT_3210, 4'h5, 28, 4'hF, 7'h7F};
        vecs[12] = '{PAT_ALL,  4'hF, 4,  4'hE, 7'h00};
        vecs[13] = '{PAT_ALL,  4'hF, 25, 4'hF, 7'h7F};
        vecs[14] = '{PAT_3210, 4'h0, 5,  4'hF, 7'h7F};

        // Reset state and idle scan.
        #3;
        chk("reset_an", 32'(an_n), 32'hF);
        chk("reset_seg", 32'(seg_n), 32'h7F);
        chk("reset_tick", 32'(frame_tick), 32'd0);
        #20;
        rst = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            tick();
            chk("idle_an", 32'(an_n), 32'hF);
            chk("idle_seg", 32'(seg_n), 32'h7F);
            chk("idle_tick", 32'(frame_tick), 32'((n % 32) == 0));
        end

        // Table: load a pattern, wait for it to become active, sample a phase.
        for (int v = 0; v < 15; v++) begin
            wait_tick();
            do_load(vecs[v].seg, vecs[v].en);
            wait_tick();
            ticks(vecs[v].phase + 1);
            chk("vec_an", 32'(an_n), 32'(vecs[v].an));
            chk("vec_seg", 32'(seg_n), 32'(vecs[v].sg));
        end

        // Full-frame basic scan: each digit lit for 6 cycles, 8 dark cycles.
        exp_seg[0] = 7'h40;
        exp_seg[1] = 7'h79;
        exp_seg[2] = 7'h24;
        exp_seg[3] = 7'h30;
        for (int i = 0; i < 4; i++) lo_cnt[i] = 0;
        dark_cnt = 0;
        wait_tick();
        do_load(PAT_3210, 4'hF);
        wait_tick();
        for (int p = 0; p < 32; p++) begin
            tick();
            if (an_n == 4'hF) dark_cnt++;
            for (int i = 0; i < 4; i++) begin
                onehot = 4'b0001 << i;
                if (an_n == ~onehot) begin
                    lo_cnt[i]++;
                    chk("scan_seg", 32'(seg_n), 32'(exp_seg[i]));
                    chk("scan_order", 32'(p / 8), 32'(i));
                end
            end
        end
        for (int i = 0; i < 4; i++) chk("scan_lit_cycles", 32'(lo_cnt[i]), 32'd6);
        chk("scan_dark_cycles", 32'(dark_cnt), 32'd8);

        // Tear-free: A active, B loaded mid-frame at idx 1.
        wait_tick();
        do_load(PAT_3210, 4'hF);
        wait_tick();
        ticks(10);
        do_load(PAT_B, 4'hF);
        ticks(8);
        chk("tear_cur_an", 32'(an_n), 32'hB);
        chk("tear_cur_seg", 32'(seg_n), 32'h24);
        wait_tick();
        ticks(19);
        chk("tear_next_seg", 32'(seg_n), 32'h7D);
        // C loaded on the boundary edge itself.
        ticks(12);
        load     = 1'b1;
        seg_in   = PAT_C;
        digit_en = 4'hF;
        tick();
        load     = 1'b0;
        chk("bnd_tick", 32'(frame_tick), 32'd1);
        ticks(19);
        chk("bnd_still_b", 32'(seg_n), 32'h7D);
        wait_tick();
        ticks(19);
        chk("bnd_then_c", 32'(seg_n), 32'h5F);

        // Async reset while digit 1 lit at cnt 4.
        wait_tick();
        ticks(13);
        chk("pre_rst_an", 32'(an_n), 32'hD);
        chk("pre_rst_seg", 32'(seg_n), 32'h3F);
        #2;
        rst = 1'b1;
        #1;
        chk("async_an", 32'(an_n), 32'hF);
        chk("async_seg", 32'(seg_n), 32'h7F);
        chk("async_tick", 32'(frame_tick), 32'd0);
        check_inv();
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        do_load(PAT_3210, 4'hF);
        chk("post_rst_an", 32'(an_n), 32'hF);
        for (int n = 2; n <= 32; n++) begin
            tick();
            chk("post_rst_dark", 32'(an_n), 32'hF);
            chk("post_rst_tick", 32'(frame_tick), 32'(n == 32));
        end
        ticks(3);
        chk("restart_an", 32'(an_n), 32'hE);
        chk("restart_seg", 32'(seg_n), 32'h40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
